// File: rtl/exec_core_pkg.sv
// exec_core_pkg: shared types and constants for the exec_core execution unit.
//   fn_e    - function select encoding carried on the 4-bit fn input
//   state_e - sequencer states (IDLE -> RD -> EX -> WB -> IDLE)
//   FLG_*   - bit positions inside the 4-bit flag register
package exec_core_pkg;

  typedef enum logic [3:0] {
    FN_MOV = 4'd0,
    FN_LDI = 4'd1,
    FN_ADD = 4'd2,
    FN_SUB = 4'd3,
    FN_AND = 4'd4,
    FN_OR  = 4'd5,
    FN_XOR = 4'd6,
    FN_SHL = 4'd7,
    FN_SHR = 4'd8,
    FN_CMP = 4'd9,
    FN_INC = 4'd10,
    FN_ADC = 4'd11,
    FN_MUL = 4'd12
  } fn_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RD,
    ST_EX,
    ST_WB
  } state_e;

  localparam int FLG_ZERO  = 0;
  localparam int FLG_GT    = 1;
  localparam int FLG_SHIFT = 2;
  localparam int FLG_CARRY = 3;

endpackage

// File: rtl/exec_core_if.sv
// exec_core_if: request/response and debug-read signals of exec_core.
//   start, fn, op1, op2, op3, imm   request from the controller
//   busy, done, err, flags, result  status back to the controller
//   dbg_addr / dbg_data             combinational register read-back
// AW must equal $clog2(NREGS) of the attached exec_core.
// Modports: master (controller / bench), slave (exec_core).
interface exec_core_if #(
  parameter int WIDTH = 8,
  parameter int AW    = 3
);
  logic             start;
  logic [3:0]       fn;
  logic [AW-1:0]    op1;
  logic [AW-1:0]    op2;
  logic [AW-1:0]    op3;
  logic [WIDTH-1:0] imm;
  logic             busy;
  logic             done;
  logic             err;
  logic [3:0]       flags;
  logic [WIDTH-1:0] result;
  logic [AW-1:0]    dbg_addr;
  logic [WIDTH-1:0] dbg_data;

  modport master (
    output start, fn, op1, op2, op3, imm, dbg_addr,
    input  busy, done, err, flags, result, dbg_data
  );

  modport slave (
    input  start, fn, op1, op2, op3, imm, dbg_addr,
    output busy, done, err, flags, result, dbg_data
  );
endinterface

// File: rtl/exec_core_alu.sv
// exec_core_alu: combinational ALU for exec_core.
//   a, b      captured source operands
//   imm       latched immediate (LDI)
//   fn        function select (fn_e encoding)
//   flags_in  current flag register (carry-in for ADC, unchanged bits pass through)
//   result    computed value, truncated to WIDTH
//   flags_out next flag register value
//   write_en  operation writes the destination register
//   illegal   fn selects no legal operation (13-15, or 12 when MUL is disabled)
// Optional feature: EXEC_CORE_MUL_EN enables fn=12 (MUL); otherwise MUL is illegal.
module exec_core_alu
  import exec_core_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] imm,
  input  logic [3:0]       fn,
  input  logic [3:0]       flags_in,
  output logic [WIDTH-1:0] result,
  output logic [3:0]       flags_out,
  output logic             write_en,
  output logic             illegal
);

  fn_e              fn_sel;
  logic [WIDTH:0]   sum;
`ifdef EXEC_CORE_MUL_EN
  logic [2*WIDTH-1:0] prod;
`endif

  assign fn_sel = fn_e'(fn);

  always_comb begin
    result    = '0;
    flags_out = flags_in;
    write_en  = 1'b1;
    illegal   = 1'b0;
    sum       = '0;
`ifdef EXEC_CORE_MUL_EN
    prod      = '0;
`endif
    case (fn_sel)
      FN_MOV: result = a;
      FN_LDI: result = imm;
      FN_ADD: begin
        sum    = {1'b0, a} + {1'b0, b};
        result = sum[WIDTH-1:0];
        flags_out[FLG_CARRY] = sum[WIDTH];
      end
      FN_SUB: begin
        // the extended ninth bit of the difference is exactly the borrow (a < b)
        sum    = {1'b0, a} - {1'b0, b};
        result = sum[WIDTH-1:0];
        flags_out[FLG_CARRY] = sum[WIDTH];
      end
      FN_AND: result = a & b;
      FN_OR:  result = a | b;
      FN_XOR: result = a ^ b;
      FN_SHL: begin
        result = {a[WIDTH-2:0], 1'b0};
        flags_out[FLG_SHIFT] = a[WIDTH-1];
      end
      FN_SHR: begin
        result = {1'b0, a[WIDTH-1:1]};
        flags_out[FLG_SHIFT] = a[0];
      end
      FN_CMP: begin
        write_en = 1'b0;
        flags_out[FLG_GT] = (a > b);
      end
      FN_INC: begin
        sum    = {1'b0, a} + {{WIDTH{1'b0}}, 1'b1};
        result = sum[WIDTH-1:0];
        flags_out[FLG_CARRY] = sum[WIDTH];
      end
      FN_ADC: begin
        sum    = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, flags_in[FLG_CARRY]};
        result = sum[WIDTH-1:0];
        flags_out[FLG_CARRY] = sum[WIDTH];
      end
`ifdef EXEC_CORE_MUL_EN
      FN_MUL: begin
        prod   = {{WIDTH{1'b0}}, a} * {{WIDTH{1'b0}}, b};
        result = prod[WIDTH-1:0];
        flags_out[FLG_CARRY] = (prod[2*WIDTH-1:WIDTH] != '0);
      end
`endif
      default: begin
        write_en = 1'b0;
        illegal  = 1'b1;
      end
    endcase

    // CMP derives zero from equality; MOV/LDI/illegal leave it alone
    if (fn_sel == FN_CMP) begin
      flags_out[FLG_ZERO] = (a == b);
    end else if (write_en && fn_sel != FN_MOV && fn_sel != FN_LDI) begin
      flags_out[FLG_ZERO] = (result == '0);
    end
  end

endmodule

// File: rtl/exec_core.sv
// exec_core: register file + ALU behind a start/done handshake.
//   clock     rising-edge clock
//   reset     asynchronous active-high reset
//   bus       exec_core_if slave: start/fn/op1/op2/op3/imm in,
//             busy/done/err/flags/result out, dbg_addr in / dbg_data out
// Every operation takes IDLE -> RD -> EX -> WB -> IDLE; done/err are registered
// so they pulse in the cycle after WB, when the core is already back in IDLE.
// Optional feature: EXEC_CORE_MUL_EN (see exec_core_alu) enables MUL.
module exec_core
  import exec_core_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int NREGS = 8
) (
  input logic        clock,
  input logic        reset,
  exec_core_if.slave bus
);

  localparam int AW = $clog2(NREGS);

  state_e           state;
  state_e           state_next;
  logic             accept;
  logic [3:0]       fn_q;
  logic [AW-1:0]    op1_q;
  logic [AW-1:0]    op2_q;
  logic [AW-1:0]    op3_q;
  logic [WIDTH-1:0] imm_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] result_q;
  logic [3:0]       flags_q;
  logic             wr_q;
  logic             illegal_q;
  logic             done_q;
  logic             err_q;
  logic [WIDTH-1:0] regs [NREGS];

  logic [WIDTH-1:0] alu_result;
  logic [3:0]       alu_flags;
  logic             alu_write;
  logic             alu_illegal;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_next;
  end

  // start is only looked at in IDLE, so holding it through an operation is harmless
  always_comb begin
    state_next = state;
    accept     = 1'b0;
    case (state)
      ST_IDLE: begin
        if (bus.start) begin
          accept     = 1'b1;
          state_next = ST_RD;
        end
      end
      ST_RD:   state_next = ST_EX;
      ST_EX:   state_next = ST_WB;
      ST_WB:   state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  // result only moves on writing operations so it holds the last written value
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      fn_q      <= '0;
      op1_q     <= '0;
      op2_q     <= '0;
      op3_q     <= '0;
      imm_q     <= '0;
      a_q       <= '0;
      b_q       <= '0;
      result_q  <= '0;
      flags_q   <= '0;
      wr_q      <= 1'b0;
      illegal_q <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      done_q <= (state == ST_WB);
      err_q  <= (state == ST_WB) && illegal_q;
      if (accept) begin
        fn_q  <= bus.fn;
        op1_q <= bus.op1;
        op2_q <= bus.op2;
        op3_q <= bus.op3;
        imm_q <= bus.imm;
      end
      if (state == ST_RD) begin
        a_q <= regs[op1_q];
        b_q <= regs[op2_q];
      end
      if (state == ST_EX) begin
        flags_q   <= alu_flags;
        wr_q      <= alu_write;
        illegal_q <= alu_illegal;
        if (alu_write) result_q <= alu_result;
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NREGS; i++) regs[i] <= '0;
    end else if (state == ST_WB && wr_q) begin
      regs[op3_q] <= result_q;
    end
  end

  exec_core_alu #(.WIDTH(WIDTH)) u_alu (
    .a         (a_q),
    .b         (b_q),
    .imm       (imm_q),
    .fn        (fn_q),
    .flags_in  (flags_q),
    .result    (alu_result),
    .flags_out (alu_flags),
    .write_en  (alu_write),
    .illegal   (alu_illegal)
  );

  assign bus.busy     = (state != ST_IDLE);
  assign bus.done     = done_q;
  assign bus.err      = err_q;
  assign bus.flags    = flags_q;
  assign bus.result   = result_q;
  assign bus.dbg_data = regs[bus.dbg_addr];

endmodule
